// File: rtl/dct8_fwd.sv
// dct8_fwd: forward 8-point HEVC integer DCT, one row/column of residuals per transfer.
//
// Pipeline: S1 registers the input samples, S2 computes the even/odd butterfly,
// S3 computes the shift-and-add coefficient sums, then rounds, shifts and registers y.
// All stages advance together when adv = out_ready_i | ~out_valid_o. No bubble collapsing.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   in_valid_i / in_ready_o    : input handshake; x0_i..x7_i are signed samples, x0 first
//   out_valid_o / out_ready_i  : output handshake; y0_o..y7_o are signed coefficients, y0 = DC
//
// Optional build macro DCT8_FWD_SAT_EN: clamp each y to the WIDTH_Y range instead of wrapping.
module dct8_fwd #(
  parameter int unsigned WIDTH_X = 9,
  parameter int unsigned WIDTH_Y = 16,
  parameter int unsigned SHIFT   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [WIDTH_X-1:0] x0_i,
  input  logic signed [WIDTH_X-1:0] x1_i,
  input  logic signed [WIDTH_X-1:0] x2_i,
  input  logic signed [WIDTH_X-1:0] x3_i,
  input  logic signed [WIDTH_X-1:0] x4_i,
  input  logic signed [WIDTH_X-1:0] x5_i,
  input  logic signed [WIDTH_X-1:0] x6_i,
  input  logic signed [WIDTH_X-1:0] x7_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [WIDTH_Y-1:0] y0_o,
  output logic signed [WIDTH_Y-1:0] y1_o,
  output logic signed [WIDTH_Y-1:0] y2_o,
  output logic signed [WIDTH_Y-1:0] y3_o,
  output logic signed [WIDTH_Y-1:0] y4_o,
  output logic signed [WIDTH_Y-1:0] y5_o,
  output logic signed [WIDTH_Y-1:0] y6_o,
  output logic signed [WIDTH_Y-1:0] y7_o
);

  localparam int unsigned BfW  = WIDTH_X + 2;
  // One bit above the WIDTH_X+9 accumulator so the rounding add cannot wrap.
  localparam int unsigned RndW = WIDTH_X + 10;
  localparam int unsigned Rnd  = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));

  typedef logic signed [WIDTH_X-1:0] x_t;
  typedef logic signed [BfW-1:0]     bf_t;
  typedef logic signed [RndW-1:0]    acc_t;
  typedef logic signed [WIDTH_Y-1:0] y_t;

`ifdef DCT8_FWD_SAT_EN
  localparam logic signed [31:0] YMax = (32'sd1 <<< (WIDTH_Y - 1)) - 32'sd1;
  localparam logic signed [31:0] YMin = -YMax - 32'sd1;
`endif

  // Constant multiply as a sum of shifted copies; c is always a small elaboration constant.
  function automatic acc_t cmul(bf_t v, int unsigned c);
    acc_t ext;
    acc_t r;
    ext = acc_t'(v);
    r   = '0;
    for (int i = 0; i < 7; i++) begin
      if (c[i]) r = r + (ext <<< i);
    end
    return r;
  endfunction

  function automatic y_t fin(acc_t a);
    acc_t              r;
    logic signed [31:0] w;
    r = (a + acc_t'(Rnd)) >>> SHIFT;
    w = 32'(r);
`ifdef DCT8_FWD_SAT_EN
    if (w > YMax) begin
      w = YMax;
    end else if (w < YMin) begin
      w = YMin;
    end
`endif
    return y_t'(w);
  endfunction

  logic adv;
  x_t   x_in [8];

  logic v1_q, v2_q, v3_q;
  x_t   x_q [8];
  bf_t  o_q [4], o_d [4];
  bf_t  e [4];
  bf_t  ee0_q, ee1_q, eo0_q, eo1_q;
  bf_t  ee0_d, ee1_d, eo0_d, eo1_d;
  acc_t a [8];
  y_t   y_q [8], y_d [8];

  assign x_in = '{x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i};

  assign adv        = out_ready_i | ~v3_q;
  assign in_ready_o = adv;

  // S2 butterfly.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      e[k]   = bf_t'(x_q[k]) + bf_t'(x_q[7-k]);
      o_d[k] = bf_t'(x_q[k]) - bf_t'(x_q[7-k]);
    end
    ee0_d = e[0] + e[3];
    ee1_d = e[1] + e[2];
    eo0_d = e[0] - e[3];
    eo1_d = e[1] - e[2];
  end

  // S3 coefficient sums. ee0+ee1 is split across two products so it never needs a wider operand.
  always_comb begin
    a[0] = cmul(ee0_q, 64) + cmul(ee1_q, 64);
    a[4] = cmul(ee0_q, 64) - cmul(ee1_q, 64);
    a[2] = cmul(eo0_q, 83) + cmul(eo1_q, 36);
    a[6] = cmul(eo0_q, 36) - cmul(eo1_q, 83);
    a[1] = cmul(o_q[0], 89) + cmul(o_q[1], 75) + cmul(o_q[2], 50) + cmul(o_q[3], 18);
    a[3] = cmul(o_q[0], 75) - cmul(o_q[1], 18) - cmul(o_q[2], 89) - cmul(o_q[3], 50);
    a[5] = cmul(o_q[0], 50) - cmul(o_q[1], 89) + cmul(o_q[2], 18) + cmul(o_q[3], 75);
    a[7] = cmul(o_q[0], 18) - cmul(o_q[1], 50) + cmul(o_q[2], 75) - cmul(o_q[3], 89);
    for (int k = 0; k < 8; k++) begin
      y_d[k] = fin(a[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      x_q   <= '{default: '0};
      o_q   <= '{default: '0};
      ee0_q <= '0;
      ee1_q <= '0;
      eo0_q <= '0;
      eo1_q <= '0;
      y_q   <= '{default: '0};
    end else if (adv) begin
      v1_q <= in_valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // Data registers only load behind a valid token; bubbles leave them untouched.
      if (in_valid_i) x_q <= x_in;
      if (v1_q) begin
        o_q   <= o_d;
        ee0_q <= ee0_d;
        ee1_q <= ee1_d;
        eo0_q <= eo0_d;
        eo1_q <= eo1_d;
      end
      if (v2_q) y_q <= y_d;
    end
  end

  assign out_valid_o = v3_q;
  assign y0_o = y_q[0];
  assign y1_o = y_q[1];
  assign y2_o = y_q[2];
  assign y3_o = y_q[3];
  assign y4_o = y_q[4];
  assign y5_o = y_q[5];
  assign y6_o = y_q[6];
  assign y7_o = y_q[7];

endmodule

// File: tb/tb_dct8_fwd.sv
// Directed bench for dct8_fwd: table of hand-computed vectors, plus backpressure, reset and
// WIDTH_Y = 14 overflow sequences.
module tb_dct8_fwd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready;
  logic in_ready, out_valid, in_ready14, out_valid14;
  logic signed [8:0]  x   [8];
  logic signed [15:0] y   [8];
  logic signed [13:0] y14 [8];

  dct8_fwd dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x0_i(x[0]), .x1_i(x[1]), .x2_i(x[2]), .x3_i(x[3]),
    .x4_i(x[4]), .x5_i(x[5]), .x6_i(x[6]), .x7_i(x[7]),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y0_o(y[0]), .y1_o(y[1]), .y2_o(y[2]), .y3_o(y[3]),
    .y4_o(y[4]), .y5_o(y[5]), .y6_o(y[6]), .y7_o(y[7])
  );

  dct8_fwd #(.WIDTH_Y(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready14),
    .x0_i(x[0]), .x1_i(x[1]), .x2_i(x[2]), .x3_i(x[3]),
    .x4_i(x[4]), .x5_i(x[5]), .x6_i(x[6]), .x7_i(x[7]),
    .out_valid_o(out_valid14), .out_ready_i(out_ready),
    .y0_o(y14[0]), .y1_o(y14[1]), .y2_o(y14[2]), .y3_o(y14[3]),
    .y4_o(y14[4]), .y5_o(y14[5]), .y6_o(y14[6]), .y7_o(y14[7])
  );

  typedef struct packed {
    logic [7:0][8:0]  x;
    logic [7:0][15:0] y;
  } vec_t;

  localparam int NVec = 6;
  vec_t  tbl   [NVec];
  string names [NVec];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic set_vec(input int i, input string nm, input int xs[8], input int ys[8]);
    names[i] = nm;
    for (int k = 0; k < 8; k++) begin
      tbl[i].x[k] = 9'(xs[k]);
      tbl[i].y[k] = 16'(ys[k]);
    end
  endtask

  task automatic load_x(input int idx);
    for (int k = 0; k < 8; k++) x[k] = tbl[idx].x[k];
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_y(input string nm, input int idx);
    bit    ok;
    string as, es;
    ok = (out_valid === 1'b1);
    as = "";
    es = "";
    for (int k = 0; k < 8; k++) begin
      if (y[k] !== tbl[idx].y[k]) ok = 0;
      as = {as, $sformatf(" %0d", y[k])};
      es = {es, $sformatf(" %0d", $signed(tbl[idx].y[k]))};
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got valid=%b y=%s, expected valid=1 y=%s", nm, out_valid, as, es);
    end
  endtask

  task automatic check_idle(input string nm);
    bit ok;
    ok = (out_valid === 1'b0);
    for (int k = 0; k < 8; k++) if (y[k] !== 16'sd0) ok = 0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got valid=%b y0=%0d y7=%0d, expected valid=0 y=0",
               nm, out_valid, y[0], y[7]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int q[$];
    int seqv[5];
    int sent, got, cyc, exp14;

    set_vec(0, "dc10",    '{10, 10, 10, 10, 10, 10, 10, 10}, '{1280, 0, 0, 0, 0, 0, 0, 0});
    set_vec(1, "impulse", '{1, 0, 0, 0, 0, 0, 0, 0},         '{16, 22, 21, 19, 16, 13, 9, 5});
    set_vec(2, "max255",  '{255, 255, 255, 255, 255, 255, 255, 255},
                          '{32640, 0, 0, 0, 0, 0, 0, 0});
    set_vec(3, "min256",  '{-256, -256, -256, -256, -256, -256, -256, -256},
                          '{-32768, 0, 0, 0, 0, 0, 0, 0});
    set_vec(4, "alt",     '{1, -1, 1, -1, 1, -1, 1, -1},     '{0, 23, 0, 27, 0, 41, 0, 116});
    set_vec(5, "ramp",    '{0, 1, 2, 3, 4, 5, 6, 7},         '{448, -291, 0, -29, 0, -8, 0, -3});

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) x[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset_out");
    check_bit("reset_in_ready", in_ready, 1'b1);

    // Single vectors: result exactly 3 cycles after acceptance, valid for one cycle.
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      load_x(i);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_bit({names[i], "_lat1"}, out_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check_y(names[i], i);
      @(negedge clk);
      #1;
      check_bit({names[i], "_pulse"}, out_valid, 1'b0);
    end

    // WIDTH_Y = 14 instance overflows on the all-255 DC term.
`ifdef DCT8_FWD_SAT_EN
    exp14 = 8191;
`else
    exp14 = -128;
`endif
    @(negedge clk);
    load_x(2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_bit("w14_valid", out_valid14, 1'b1);
    check_int("w14_y0", int'(y14[0]), exp14);
    check_int("w14_y1", int'(y14[1]), 0);

    // Backpressure: five back-to-back vectors, out_ready low for cycles 4..7.
    seqv = '{1, 0, 1, 0, 4};
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 5);
      if (sent < 5) load_x(seqv[sent]);
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check_int("bp_extra_output", 1, 0);
        end else begin
          check_y(out_ready ? "bp_out" : "bp_hold", q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (!out_ready) check_bit("bp_in_ready_stall", in_ready, 1'b0);
      if (in_valid && in_ready) begin
        q.push_back(seqv[sent]);
        sent++;
      end
      cyc++;
    end
    check_int("bp_delivered", got, 5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_bit("bp_drain", out_valid, 1'b0);
    check_int("bp_queue_empty", q.size(), 0);

    // Reset with two vectors in flight.
    @(negedge clk);
    load_x(1);
    in_valid = 1'b1;
    @(negedge clk);
    load_x(0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("rst_mid_out");
    check_bit("rst_mid_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_bit("rst_discard", out_valid, 1'b0);
    end
    load_x(5);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_bit("rst_after_lat1", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check_bit("rst_after_lat2", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check_y("rst_after_vec", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
